// File: rtl/audio_frame_capture.sv
// rtl/audio_frame_capture.sv - one-channel stereo sample capture into a ping-pong frame buffer, streamed out per frame
// Optional MONO_MIX_EN: store (L+R)>>>1 instead of the ch_sel-selected channel.
module audio_frame_capture #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAME_LEN  = 256,
    parameter int DROP_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  ch_sel,
    input  logic                  capture_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           out_data,
    output logic                  out_first,
    output logic                  out_last,
    output logic [DROP_W-1:0]     drop_cnt,
    output logic                  overflow
);

    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, PRIME, STREAM} rd_state_t;

    logic [15:0]      mem [0:2*FRAME_LEN-1];
    logic [1:0]       bank_full;
    logic             wr_bank;
    logic [IDX_W-1:0] wr_idx;
    logic             dropping;
    logic             rd_bank;
    logic [IDX_W-1:0] rd_idx;
    rd_state_t        state, state_nxt;

    logic             handshake, rd_last, free_now, rd_en;
    logic [IDX_W-1:0] rd_addr_idx;
    logic             strobe, bank_free, accept, drop_now, frame_done;
    logic [15:0]      sample;

`ifdef MONO_MIX_EN
    logic signed [16:0] mix_sum;
    assign mix_sum = $signed({in_data[15], in_data[15:0]}) + $signed({in_data[31], in_data[31:16]});
    assign sample  = mix_sum[16:1];
`else
    logic frame_ch, cur_ch;
    // The first sample of a frame uses ch_sel directly; later ones use the latched value.
    assign cur_ch = (wr_idx == '0) ? ch_sel : frame_ch;
    assign sample = cur_ch ? in_data[31:16] : in_data[15:0];
`endif

    assign out_valid = (state == STREAM);
    assign rd_last   = (rd_idx == LAST_IDX);
    assign handshake = out_valid && out_ready;
    assign free_now  = handshake && rd_last;
    assign out_first = out_valid && (rd_idx == '0);
    assign out_last  = out_valid && rd_last;

    always_comb begin
        state_nxt   = state;
        rd_en       = 1'b0;
        rd_addr_idx = rd_idx + 1'b1;
        case (state)
            IDLE: begin
                if (bank_full[rd_bank]) state_nxt = PRIME;
            end
            PRIME: begin
                rd_en       = 1'b1;
                rd_addr_idx = '0;
                state_nxt   = STREAM;
            end
            STREAM: begin
                if (handshake) begin
                    if (rd_last) state_nxt = bank_full[~rd_bank] ? PRIME : IDLE;
                    else         rd_en     = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rd_bank  <= 1'b0;
            rd_idx   <= '0;
            out_data <= '0;
        end else begin
            state <= state_nxt;
            if (free_now) rd_bank <= ~rd_bank;
            if (state == PRIME)            rd_idx <= '0;
            else if (handshake && !rd_last) rd_idx <= rd_idx + 1'b1;
            if (rd_en) out_data <= mem[{rd_bank, rd_addr_idx}];
        end
    end

    // A bank freed by the reader this cycle is already usable by a frame starting now.
    assign strobe     = in_valid && capture_en;
    assign bank_free  = !bank_full[wr_bank] || (free_now && (rd_bank == wr_bank));
    assign accept     = strobe && ((wr_idx == '0) ? bank_free : !dropping);
    assign drop_now   = strobe && ((wr_idx == '0) ? !bank_free : dropping);
    assign frame_done = accept && (wr_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (accept) mem[{wr_bank, wr_idx}] <= sample;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_bank   <= 1'b0;
            wr_idx    <= '0;
            dropping  <= 1'b0;
            bank_full <= 2'b00;
            drop_cnt  <= '0;
            overflow  <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (frame_done && (wr_bank == 1'(b)))    bank_full[b] <= 1'b1;
                else if (free_now && (rd_bank == 1'(b))) bank_full[b] <= 1'b0;
            end
            if (!capture_en) begin
                wr_idx   <= '0;
                dropping <= 1'b0;
            end else if (strobe) begin
                if (wr_idx == LAST_IDX) begin
                    wr_idx   <= '0;
                    dropping <= 1'b0;
                    if (drop_now) begin
                        overflow <= 1'b1;
                        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
                    end
                end else begin
                    wr_idx   <= wr_idx + 1'b1;
                    dropping <= drop_now;
                end
                if (frame_done) wr_bank <= ~wr_bank;
            end
        end
    end

`ifndef MONO_MIX_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                frame_ch <= 1'b0;
        else if (strobe && (wr_idx == '0))           frame_ch <= ch_sel;
    end
`endif

endmodule

// File: tb/tb_audio_frame_capture.sv
// tb/tb_audio_frame_capture.sv - directed scoreboard bench for audio_frame_capture with FRAME_LEN=8
module tb_audio_frame_capture;

    localparam int FL = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        ch_sel = 1'b0;
    logic        capture_en = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_first;
    logic        out_last;
    logic [7:0]  drop_cnt;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [15:0] d;
        logic        f;
        logic        l;
    } exp_t;

    exp_t q[$];

    audio_frame_capture #(.DATA_WIDTH(32), .FRAME_LEN(FL), .DROP_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .ch_sel(ch_sel), .capture_en(capture_en), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_first(out_first),
        .out_last(out_last), .drop_cnt(drop_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_sample(input logic [31:0] d, input logic ch);
`ifdef MONO_MIX_EN
        logic signed [16:0] s;
        s = $signed({d[15], d[15:0]}) + $signed({d[31], d[31:16]});
        return s[16:1];
`else
        return ch ? d[31:16] : d[15:0];
`endif
    endfunction

    task automatic push(input logic [15:0] d, input int idx);
        exp_t e;
        e.d = d;
        e.f = (idx == 0);
        e.l = (idx == FL - 1);
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_queue_empty"}, q.size(), 0);
        check({tag, "_idle"}, out_valid, 1'b0);
        step();
    endtask

    logic        hold_pend = 1'b0;
    logic [15:0] hold_data;
    logic        hold_first, hold_last;

    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_data", out_data, hold_data);
                check("hold_marks", {out_first, out_last}, {hold_first, hold_last});
            end
            if (out_valid && out_ready) begin
                check("sb_nonempty", (q.size() != 0), 1'b1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("out_data", out_data, e.d);
                    check("out_first", out_first, e.f);
                    check("out_last", out_last, e.l);
                end
                hold_pend = 1'b0;
            end else if (out_valid) begin
                hold_pend  = 1'b1;
                hold_data  = out_data;
                hold_first = out_first;
                hold_last  = out_last;
            end else begin
                hold_pend = 1'b0;
            end
        end
    end

    initial begin
        logic [31:0] d;

        // Reset state
        repeat (3) step();
        reset_n = 1'b1;
        step();
        check("rst_valid", out_valid, 1'b0);
        check("rst_marks", {out_first, out_last}, 2'b00);
        check("rst_data", out_data, 16'h0000);
        check("rst_drop_cnt", drop_cnt, 8'd0);
        check("rst_overflow", overflow, 1'b0);

        // Channel 0 frame, ready high, latency and throughput
        capture_en = 1'b1;
        ch_sel     = 1'b0;
        out_ready  = 1'b1;
        for (int k = 1; k <= FL; k++) begin
            d = {16'hAAAA, 16'(k)};
            push(exp_sample(d, 1'b0), k - 1);
            strobe(d);
        end
        @(negedge clk);
        check("lat_t1", out_valid, 1'b0);
        @(negedge clk);
        check("lat_t2", out_valid, 1'b0);
        @(negedge clk);
        check("lat_t3_valid", out_valid, 1'b1);
        check("lat_t3_first", out_first, 1'b1);
        for (int i = 1; i < FL; i++) begin
            @(negedge clk);
            check("throughput", out_valid, 1'b1);
        end
        drain("s1");

        // Channel 1 frame, ch_sel toggled mid-frame
        ch_sel = 1'b1;
        for (int k = 1; k <= FL; k++) begin
            d = {16'(16'h0010 + k), 16'h0000};
            push(exp_sample(d, 1'b1), k - 1);
            strobe(d);
            if (k == 3) ch_sel = 1'b0;
        end
        drain("s2");

        // Reader stalled: two frames buffered, third dropped
        ch_sel    = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 3 * FL; k++) begin
            d = {16'(16'hF000 + k), 16'(16'h0100 + k)};
            if (k < 2 * FL) push(exp_sample(d, 1'b0), k % FL);
            strobe(d);
        end
        step();
        check("drop_cnt_one", drop_cnt, 8'd1);
        check("overflow_set", overflow, 1'b1);
        check("stall_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        drain("s3");

        // out_ready toggling every cycle
        for (int k = 0; k < FL; k++) begin
            d = {16'h1234, 16'(16'h0200 + k)};
            push(exp_sample(d, 1'b0), k);
            in_valid  = 1'b1;
            in_data   = d;
            out_ready = k[0];
            step();
        end
        in_valid = 1'b0;
        for (int n = 0; n < 100 && q.size() != 0; n++) begin
            out_ready = ~out_ready;
            step();
        end
        out_ready = 1'b1;
        drain("s4");

        // capture_en dropped after 5 samples abandons the partial frame
        for (int k = 0; k < 5; k++) strobe({16'h0, 16'(16'h0300 + k)});
        capture_en = 1'b0;
        strobe(32'h0000_0EEE);
        strobe(32'h0000_0EEF);
        capture_en = 1'b1;
        repeat (5) step();
        check("no_early_out", out_valid, 1'b0);
        for (int k = 0; k < FL; k++) begin
            d = {16'h0, 16'(16'h0400 + k)};
            push(exp_sample(d, 1'b0), k);
            strobe(d);
        end
        drain("s5");
        check("drop_cnt_kept", drop_cnt, 8'd1);

`ifdef MONO_MIX_EN
        for (int k = 0; k < FL; k++) begin
            d = k[0] ? 32'h7FFF_0001 : 32'h8000_8000;
            push(k[0] ? 16'h4000 : 16'h8000, k);
            strobe(d);
        end
        drain("mono");
`endif

        // Reset in the middle of a frame
        for (int k = 0; k < 3; k++) strobe({16'h0, 16'(16'h0500 + k)});
        reset_n = 1'b0;
        #2;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_data", out_data, 16'h0000);
        check("mid_rst_overflow", overflow, 1'b0);
        check("mid_rst_drop_cnt", drop_cnt, 8'd0);
        step();
        reset_n = 1'b1;
        step();
        for (int k = 0; k < FL; k++) begin
            d = {16'h0, 16'(16'h0600 + k)};
            push(exp_sample(d, 1'b0), k);
            strobe(d);
        end
        drain("s6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
